// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmit path: framing modes, channel tags
// and the width of the underflow counter.
package i2s_pkg;

   localparam logic I2S_MODE_PHILIPS = 1'b0;
   localparam logic I2S_MODE_LJ      = 1'b1;

   localparam logic LR_LEFT  = 1'b0;
   localparam logic LR_RIGHT = 1'b1;

   localparam int UCNT_W = 16;

endpackage : i2s_pkg

// File: rtl/i2s_sample_fifo.sv
// Synchronous sample FIFO with a combinational head read so the slot logic
// can inspect the channel tag of the oldest entry before deciding to pop.
module i2s_sample_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [LVL_W-1:0] level_reg;
   logic [LVL_W-1:0] level_next;
   logic             do_push;
   logic             do_pop;

   assign full      = (level_reg == LVL_W'(DEPTH));
   assign empty     = (level_reg == '0);
   assign level     = level_reg;
   assign head_data = mem[rd_ptr_reg];
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;

   always_comb begin
      level_next = level_reg;
      case ({do_push, do_pop})
         2'b10:   level_next = level_reg + LVL_W'(1);
         2'b01:   level_next = level_reg - LVL_W'(1);
         default: level_next = level_reg;
      endcase
   end

   // Storage carries no reset; a flush only needs the pointers cleared.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         level_reg <= level_next;
      end
   end

endmodule : i2s_sample_fifo

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: divides clk into bclk, walks slot/bit counters, pops
// channel-matched samples at slot start and shifts them out MSB first.
module i2s_tx_serializer
   import i2s_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 24,
   parameter int SLOT_WIDTH   = 32,
   parameter int CLK_DIV      = 8,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            enable,
   input  logic                            mode,
   input  logic                            sample_valid,
   output logic                            sample_ready,
   input  logic [SAMPLE_WIDTH-1:0]         sample_data,
   input  logic                            sample_lr,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            starved,
   output logic [UCNT_W-1:0]               underflow_count,
   output logic                            i2s_bclk,
   output logic                            i2s_lr,
   output logic                            i2s_data
);

   localparam int DIV_W   = $clog2(CLK_DIV);
   localparam int BIT_W   = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
   localparam int ENTRY_W = SAMPLE_WIDTH + 1;
   localparam int PAD_W   = SLOT_WIDTH - SAMPLE_WIDTH;

   logic [DIV_W-1:0]      div_reg, div_next;
   logic [BIT_W-1:0]      bit_reg, bit_next;
   logic                  ch_reg, ch_next;
   logic                  bclk_reg, bclk_next;
   logic                  lr_reg, lr_next;
   logic                  data_reg, data_next;
   logic                  prev_reg, prev_next;
   logic                  starved_reg, starved_next;
   logic                  mode_reg, mode_next;
   logic [SLOT_WIDTH-1:0] shift_reg, shift_next;
   logic [UCNT_W-1:0]     ucnt_reg, ucnt_next;

   logic                  tick;
   logic                  slot_start;
   logic                  eff_mode;
   logic                  lj_bit;
   logic [SLOT_WIDTH-1:0] load_val;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [ENTRY_W-1:0]    head_entry;
   logic                  head_lr;
   logic [SAMPLE_WIDTH-1:0] head_sample;

   assign sample_ready = !fifo_full;
   assign fifo_push    = sample_valid && !fifo_full;
   assign head_lr      = head_entry[SAMPLE_WIDTH];
   assign head_sample  = head_entry[SAMPLE_WIDTH-1:0];

   i2s_sample_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data ({sample_lr, sample_data}),
      .pop       (fifo_pop),
      .head_data (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // A tick is the clk cycle in which bclk falls and every pin updates.
   assign tick       = enable && (div_reg == DIV_W'(CLK_DIV - 1));
   assign slot_start = tick && (bit_reg == '0);
   // Mode is latched at each left-slot start and applies from that bit on.
   assign eff_mode   = (slot_start && ch_reg == LR_LEFT) ? mode : mode_reg;

   always_comb begin
      div_next     = div_reg;
      bit_next     = bit_reg;
      ch_next      = ch_reg;
      bclk_next    = bclk_reg;
      lr_next      = lr_reg;
      data_next    = data_reg;
      prev_next    = prev_reg;
      starved_next = starved_reg;
      mode_next    = mode_reg;
      shift_next   = shift_reg;
      ucnt_next    = ucnt_reg;
      fifo_pop     = 1'b0;
      lj_bit       = 1'b0;
      load_val     = '0;

      if (!enable) begin
         div_next     = '0;
         bit_next     = '0;
         ch_next      = LR_LEFT;
         bclk_next    = 1'b0;
         lr_next      = 1'b0;
         data_next    = 1'b0;
         prev_next    = 1'b0;
         starved_next = 1'b0;
         mode_next    = I2S_MODE_PHILIPS;
         shift_next   = '0;
      end else begin
         div_next  = tick ? '0 : div_reg + DIV_W'(1);
         bclk_next = (div_next >= DIV_W'(CLK_DIV / 2));
         if (tick) begin
            if (slot_start) begin
               lr_next = ch_reg;
               if (ch_reg == LR_LEFT) mode_next = mode;
               if (!fifo_empty && head_lr == ch_reg) begin
                  fifo_pop     = 1'b1;
                  load_val     = SLOT_WIDTH'(head_sample) << PAD_W;
                  starved_next = 1'b0;
               end else begin
                  // Empty FIFO or a head tagged for the other channel: mute
                  // this slot and leave the head in place to resync.
                  load_val     = '0;
                  starved_next = 1'b1;
                  if (ucnt_reg != '1) ucnt_next = ucnt_reg + UCNT_W'(1);
               end
               lj_bit     = load_val[SLOT_WIDTH-1];
               shift_next = load_val << 1;
            end else begin
               lj_bit     = shift_reg[SLOT_WIDTH-1];
               shift_next = shift_reg << 1;
            end
            data_next = (eff_mode == I2S_MODE_PHILIPS) ? prev_reg : lj_bit;
            prev_next = lj_bit;
            if (bit_reg == BIT_W'(SLOT_WIDTH - 1)) begin
               bit_next = '0;
               ch_next  = ~ch_reg;
            end else begin
               bit_next = bit_reg + BIT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_reg     <= '0;
         bit_reg     <= '0;
         ch_reg      <= LR_LEFT;
         bclk_reg    <= 1'b0;
         lr_reg      <= 1'b0;
         data_reg    <= 1'b0;
         prev_reg    <= 1'b0;
         starved_reg <= 1'b0;
         mode_reg    <= I2S_MODE_PHILIPS;
         shift_reg   <= '0;
         ucnt_reg    <= '0;
      end else begin
         div_reg     <= div_next;
         bit_reg     <= bit_next;
         ch_reg      <= ch_next;
         bclk_reg    <= bclk_next;
         lr_reg      <= lr_next;
         data_reg    <= data_next;
         prev_reg    <= prev_next;
         starved_reg <= starved_next;
         mode_reg    <= mode_next;
         shift_reg   <= shift_next;
         ucnt_reg    <= ucnt_next;
      end
   end

   // Pins drop to 0 as soon as enable falls, not one cycle later.
   assign i2s_bclk        = enable && bclk_reg;
   assign i2s_lr          = enable && lr_reg;
   assign i2s_data        = enable && data_reg;
   assign starved         = enable && starved_reg;
   assign underflow_count = ucnt_reg;

endmodule : i2s_tx_serializer

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: captures the pin stream at each bclk
// falling edge and compares slot words against hand-computed values.
module tb_i2s_tx_serializer;

   localparam int SW = 24;
   localparam int SL = 32;
   localparam int CD = 4;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          enable = 1'b0;
   logic          mode = 1'b0;
   logic          sample_valid = 1'b0;
   logic          sample_ready;
   logic [SW-1:0] sample_data = '0;
   logic          sample_lr = 1'b0;
   logic [2:0]    fifo_level;
   logic          starved;
   logic [15:0]   underflow_count;
   logic          i2s_bclk;
   logic          i2s_lr;
   logic          i2s_data;

   int checks = 0;
   int passes = 0;

   logic cap_data [0:255];
   logic cap_lr   [0:255];
   logic cap_st   [0:255];

   i2s_tx_serializer #(
      .SAMPLE_WIDTH (SW),
      .SLOT_WIDTH   (SL),
      .CLK_DIV      (CD),
      .FIFO_DEPTH   (FD)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .mode            (mode),
      .sample_valid    (sample_valid),
      .sample_ready    (sample_ready),
      .sample_data     (sample_data),
      .sample_lr       (sample_lr),
      .fifo_level      (fifo_level),
      .starved         (starved),
      .underflow_count (underflow_count),
      .i2s_bclk        (i2s_bclk),
      .i2s_lr          (i2s_lr),
      .i2s_data        (i2s_data)
   );

   always #5 clk = ~clk;

   // kind 0 = data, 1 = lr, 2 = starved; first captured bit lands in the MSB.
   function automatic logic [31:0] word_at(input int base, input int kind);
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < 32; i++) begin
         case (kind)
            0:       w[31-i] = cap_data[base+i];
            1:       w[31-i] = cap_lr[base+i];
            default: w[31-i] = cap_st[base+i];
         endcase
      end
      return w;
   endfunction

   task automatic do_reset();
      enable = 1'b0;
      sample_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Called at a negedge; the sample is taken at the following posedge.
   task automatic push(input logic lr, input logic [SW-1:0] data);
      sample_valid = 1'b1;
      sample_lr    = lr;
      sample_data  = data;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic capture(input int nbits);
      int   got = 0;
      int   cyc = 0;
      logic prev;
      @(negedge clk);
      prev = i2s_bclk;
      while (got < nbits && cyc < nbits * CD + 3 * CD + 8) begin
         @(negedge clk);
         cyc++;
         if (prev && !i2s_bclk) begin
            cap_data[got] = i2s_data;
            cap_lr[got]   = i2s_lr;
            cap_st[got]   = starved;
            got++;
         end
         prev = i2s_bclk;
      end
      checks++;
      if (got != nbits) $display("FAIL capture_timeout got=%0d required=%0d", got, nbits);
      else passes++;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (i2s_bclk !== 1'b0) $display("FAIL reset_bclk got=%b required=0", i2s_bclk); else passes++;
      checks++; if (i2s_lr !== 1'b0) $display("FAIL reset_lr got=%b required=0", i2s_lr); else passes++;
      checks++; if (i2s_data !== 1'b0) $display("FAIL reset_data got=%b required=0", i2s_data); else passes++;
      checks++; if (starved !== 1'b0) $display("FAIL reset_starved got=%b required=0", starved); else passes++;
      checks++; if (underflow_count !== 16'h0) $display("FAIL reset_ucnt got=%h required=0000", underflow_count); else passes++;
      checks++; if (fifo_level !== 3'd0) $display("FAIL reset_level got=%0d required=0", fifo_level); else passes++;
      checks++; if (sample_ready !== 1'b1) $display("FAIL reset_ready got=%b required=1", sample_ready); else passes++;
      $display("test_reset done");
   endtask

   task automatic test_philips();
      do_reset();
      mode = 1'b0;
      push(1'b0, 24'hA5A5A5);
      push(1'b1, 24'h5A5A5A);
      enable = 1'b1;
      capture(64);
      enable = 1'b0;
      checks++; if (word_at(0, 0) !== 32'h52D2D280) $display("FAIL philips_left got=%h required=52d2d280", word_at(0, 0)); else passes++;
      checks++; if (word_at(32, 0) !== 32'h2D2D2D00) $display("FAIL philips_right got=%h required=2d2d2d00", word_at(32, 0)); else passes++;
      checks++; if (word_at(0, 1) !== 32'h0) $display("FAIL philips_lr_left got=%h required=00000000", word_at(0, 1)); else passes++;
      checks++; if (word_at(32, 1) !== 32'hFFFFFFFF) $display("FAIL philips_lr_right got=%h required=ffffffff", word_at(32, 1)); else passes++;
      checks++; if ((word_at(0, 2) | word_at(32, 2)) !== 32'h0) $display("FAIL philips_starved got=%h required=00000000", word_at(0, 2) | word_at(32, 2)); else passes++;
      checks++; if (underflow_count !== 16'd0) $display("FAIL philips_ucnt got=%0d required=0", underflow_count); else passes++;
      $display("test_philips left=%h right=%h", word_at(0, 0), word_at(32, 0));
   endtask

   task automatic test_left_justified();
      do_reset();
      mode = 1'b1;
      push(1'b0, 24'hA5A5A5);
      push(1'b1, 24'h5A5A5A);
      enable = 1'b1;
      capture(64);
      enable = 1'b0;
      checks++; if (word_at(0, 0) !== 32'hA5A5A500) $display("FAIL lj_left got=%h required=a5a5a500", word_at(0, 0)); else passes++;
      checks++; if (word_at(32, 0) !== 32'h5A5A5A00) $display("FAIL lj_right got=%h required=5a5a5a00", word_at(32, 0)); else passes++;
      checks++; if (word_at(32, 1) !== 32'hFFFFFFFF) $display("FAIL lj_lr_right got=%h required=ffffffff", word_at(32, 1)); else passes++;
      $display("test_left_justified left=%h right=%h", word_at(0, 0), word_at(32, 0));
   endtask

   task automatic test_underflow();
      do_reset();
      mode = 1'b0;
      enable = 1'b1;
      capture(64);
      checks++; if ((word_at(0, 0) | word_at(32, 0)) !== 32'h0) $display("FAIL uf_data got=%h required=00000000", word_at(0, 0) | word_at(32, 0)); else passes++;
      checks++; if ((word_at(0, 2) & word_at(32, 2)) !== 32'hFFFFFFFF) $display("FAIL uf_starved got=%h required=ffffffff", word_at(0, 2) & word_at(32, 2)); else passes++;
      checks++; if (underflow_count !== 16'd2) $display("FAIL uf_count got=%0d required=2", underflow_count); else passes++;
      // Both pushes land before the next left-slot start four clocks later.
      push(1'b0, 24'h123456);
      push(1'b1, 24'h654321);
      capture(64);
      enable = 1'b0;
      checks++; if ((word_at(0, 2) | word_at(32, 2)) !== 32'h0) $display("FAIL uf_recover_starved got=%h required=00000000", word_at(0, 2) | word_at(32, 2)); else passes++;
      checks++; if (word_at(0, 0) !== 32'h091A2B00) $display("FAIL uf_recover_left got=%h required=091a2b00", word_at(0, 0)); else passes++;
      checks++; if (word_at(32, 0) !== 32'h32A19080) $display("FAIL uf_recover_right got=%h required=32a19080", word_at(32, 0)); else passes++;
      checks++; if (underflow_count !== 16'd2) $display("FAIL uf_count_frozen got=%0d required=2", underflow_count); else passes++;
      $display("test_underflow count=%0d", underflow_count);
   endtask

   task automatic test_resync();
      do_reset();
      mode = 1'b1;
      push(1'b1, 24'h111111);
      push(1'b0, 24'h222222);
      push(1'b1, 24'h333333);
      enable = 1'b1;
      capture(128);
      enable = 1'b0;
      checks++; if (word_at(0, 2) !== 32'hFFFFFFFF) $display("FAIL resync_left_muted got=%h required=ffffffff", word_at(0, 2)); else passes++;
      checks++; if (word_at(0, 0) !== 32'h0) $display("FAIL resync_left_data got=%h required=00000000", word_at(0, 0)); else passes++;
      checks++; if (word_at(32, 0) !== 32'h11111100) $display("FAIL resync_f0_right got=%h required=11111100", word_at(32, 0)); else passes++;
      checks++; if (word_at(64, 0) !== 32'h22222200) $display("FAIL resync_f1_left got=%h required=22222200", word_at(64, 0)); else passes++;
      checks++; if (word_at(96, 0) !== 32'h33333300) $display("FAIL resync_f1_right got=%h required=33333300", word_at(96, 0)); else passes++;
      checks++; if (underflow_count !== 16'd1) $display("FAIL resync_count got=%0d required=1", underflow_count); else passes++;
      $display("test_resync count=%0d", underflow_count);
   endtask

   task automatic test_backpressure();
      do_reset();
      mode = 1'b1;
      sample_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sample_lr   = i[0];
         sample_data = 24'hA00000 + SW'(i);
         @(negedge clk);
      end
      sample_valid = 1'b0;
      checks++; if (fifo_level !== 3'd4) $display("FAIL bp_level_full got=%0d required=4", fifo_level); else passes++;
      checks++; if (sample_ready !== 1'b0) $display("FAIL bp_ready got=%b required=0", sample_ready); else passes++;
      enable = 1'b1;
      capture(1);
      checks++; if (fifo_level !== 3'd3) $display("FAIL bp_level_slot0 got=%0d required=3", fifo_level); else passes++;
      checks++; if (cap_data[0] !== 1'b1) $display("FAIL bp_first_msb got=%b required=1", cap_data[0]); else passes++;
      capture(32);
      checks++; if (fifo_level !== 3'd2) $display("FAIL bp_level_slot1 got=%0d required=2", fifo_level); else passes++;
      capture(32);
      checks++; if (fifo_level !== 3'd1) $display("FAIL bp_level_slot2 got=%0d required=1", fifo_level); else passes++;
      capture(32);
      checks++; if (fifo_level !== 3'd0) $display("FAIL bp_level_slot3 got=%0d required=0", fifo_level); else passes++;
      capture(32);
      enable = 1'b0;
      checks++; if (cap_st[31] !== 1'b1) $display("FAIL bp_fifth_not_taken got=%b required=1", cap_st[31]); else passes++;
      checks++; if (underflow_count !== 16'd1) $display("FAIL bp_count got=%0d required=1", underflow_count); else passes++;
      $display("test_backpressure level=%0d count=%0d", fifo_level, underflow_count);
   endtask

   task automatic test_reset_mid_slot();
      do_reset();
      mode = 1'b1;
      push(1'b0, 24'hAAAAAA);
      push(1'b1, 24'h555555);
      push(1'b0, 24'h0F0F0F);
      push(1'b1, 24'hF0F0F0);
      enable = 1'b1;
      capture(40);
      checks++; if (i2s_lr !== 1'b1) $display("FAIL rm_in_right got=%b required=1", i2s_lr); else passes++;
      rst = 1'b1;
      #1;
      checks++; if ({i2s_bclk, i2s_lr, i2s_data} !== 3'b000) $display("FAIL rm_pins got=%b required=000", {i2s_bclk, i2s_lr, i2s_data}); else passes++;
      checks++; if (fifo_level !== 3'd0) $display("FAIL rm_level got=%0d required=0", fifo_level); else passes++;
      checks++; if (sample_ready !== 1'b1) $display("FAIL rm_ready got=%b required=1", sample_ready); else passes++;
      enable = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      push(1'b0, 24'hABCDEF);
      push(1'b1, 24'h123456);
      enable = 1'b1;
      capture(1);
      enable = 1'b0;
      checks++; if (cap_lr[0] !== 1'b0) $display("FAIL rm_first_slot_lr got=%b required=0", cap_lr[0]); else passes++;
      checks++; if (cap_st[0] !== 1'b0) $display("FAIL rm_first_slot_starved got=%b required=0", cap_st[0]); else passes++;
      checks++; if (cap_data[0] !== 1'b1) $display("FAIL rm_first_msb got=%b required=1", cap_data[0]); else passes++;
      checks++; if (fifo_level !== 3'd1) $display("FAIL rm_level_after got=%0d required=1", fifo_level); else passes++;
      $display("test_reset_mid_slot level=%0d", fifo_level);
   endtask

   initial begin
      test_reset();
      test_philips();
      test_left_justified();
      test_underflow();
      test_resync();
      test_backpressure();
      test_reset_mid_slot();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule : tb_i2s_tx_serializer
